// File: rtl/viterbi_codec.sv
// viterbi_codec: rate-1/2 K=3 convolutional encoder (g1=111, g0=101) plus hard-decision register-exchange Viterbi decoder
module viterbi_codec #(
  parameter int TB_DEPTH = 32,
  parameter int PM_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_in,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_out,
  input  logic       dec_enable,
  input  logic [1:0] dec_d_in,
  output logic       dec_d_out
);
  logic [1:0]          enc_s;
  logic [PM_W-1:0]     pm      [4];
  logic [PM_W-1:0]     pm_nx   [4];
  logic [TB_DEPTH-1:0] surv    [4];
  logic [TB_DEPTH-1:0] surv_nx [4];
  logic [PM_W:0]       acc     [4];
  logic [PM_W:0]       mn01, mn23, mn;
  logic [1:0]          b01, b23, best;

  // Hamming distance between the received symbol and the branch label from state st on input u
  function automatic logic [1:0] bm(input logic [1:0] rx, input logic [1:0] st, input logic u);
    logic [1:0] x;
    x = rx ^ {u ^ st[1] ^ st[0], u ^ st[0]};
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  // encoder: shift register {s1,s0}, output zeroed while idle
  always_ff @(posedge clk)
    if (!rst) begin
      enc_s       <= 2'b00;
      enc_d_out   <= 2'b00;
      enc_valid_o <= 1'b0;
    end else begin
      enc_valid_o <= enc_enable_i;
      enc_d_out   <= enc_enable_i ? {enc_d_in ^ enc_s[1] ^ enc_s[0], enc_d_in ^ enc_s[0]} : 2'b00;
      if (enc_enable_i) enc_s <= {enc_d_in, enc_s[1]};
    end

  // add-compare-select per next state {u,a}; predecessors {a,0} and {a,1}, ties go to {a,0}
  for (genvar g = 0; g < 4; g++) begin : acs
    localparam logic [1:0] ns = 2'(g);
    localparam logic [1:0] p0 = {ns[0], 1'b0};
    localparam logic [1:0] p1 = {ns[0], 1'b1};
    logic [PM_W:0] c0, c1;
    logic          pick;
    assign c0          = {1'b0, pm[p0]} + (PM_W+1)'(bm(dec_d_in, p0, ns[1]));
    assign c1          = {1'b0, pm[p1]} + (PM_W+1)'(bm(dec_d_in, p1, ns[1]));
    assign pick        = c1 < c0;
    assign acc[g]      = pick ? c1 : c0;
    assign surv_nx[g]  = {(pick ? surv[p1][TB_DEPTH-2:0] : surv[p0][TB_DEPTH-2:0]), ns[1]};
  end

  // normalise new metrics by their minimum and pick the best pre-update state (lowest index on ties)
  always_comb begin
    mn01 = acc[1] < acc[0] ? acc[1] : acc[0];
    mn23 = acc[3] < acc[2] ? acc[3] : acc[2];
    mn   = mn23 < mn01 ? mn23 : mn01;
    for (int i = 0; i < 4; i++) pm_nx[i] = PM_W'(acc[i] - mn);
    b01  = pm[1] < pm[0] ? 2'd1 : 2'd0;
    b23  = pm[3] < pm[2] ? 2'd3 : 2'd2;
    best = pm[b23] < pm[b01] ? b23 : b01;
  end

  // decoder state: metrics, survivors and the oldest bit of the best survivor, all held while idle
  always_ff @(posedge clk)
    if (!rst) begin
      pm        <= '{PM_W'(0), PM_W'(32), PM_W'(32), PM_W'(32)};
      surv      <= '{default: '0};
      dec_d_out <= 1'b0;
    end else if (dec_enable) begin
      pm        <= pm_nx;
      surv      <= surv_nx;
      dec_d_out <= surv[best][TB_DEPTH-1];
    end
endmodule

// File: tb/tb_viterbi_codec.sv
// tb_viterbi_codec: encoder vector table plus loopback scoreboard for the Viterbi decoder
module tb_viterbi_codec;
  localparam int TBD = 32;

  logic       clk = 0, rst = 0;
  logic       enc_enable_i = 0, enc_d_in = 0, enc_valid_o;
  logic [1:0] enc_d_out;
  logic       dec_enable = 0, dec_d_out;
  logic [1:0] dec_d_in = 0;

  viterbi_codec #(.TB_DEPTH(TBD), .PM_W(8)) dut (
    .clk(clk), .rst(rst),
    .enc_enable_i(enc_enable_i), .enc_d_in(enc_d_in),
    .enc_valid_o(enc_valid_o), .enc_d_out(enc_d_out),
    .dec_enable(dec_enable), .dec_d_in(dec_d_in), .dec_d_out(dec_d_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic en; logic u; logic v; logic [1:0] d; } enc_vec_t;

  int         tests = 0, fails = 0;
  int         dec_n, err_mode = 0;
  logic [1:0] ms, ch_d;
  logic       ch_v, prev_out;
  logic       exp_q[$];
  logic       bits[1000];
  enc_vec_t   tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] flip_for(input int n);
    int m;
    m = n % 40;
    return (err_mode == 1 && m == 10) ? 2'b11 :
           (err_mode == 2 && m == 10) ? 2'b10 :
           (err_mode == 2 && m == 11) ? 2'b01 : 2'b00;
  endfunction

  task automatic do_reset();
    rst = 0; enc_enable_i = 0; enc_d_in = 0; dec_enable = 0; dec_d_in = 0;
    @(posedge clk); #1;
    chk("rst_enc", 32'({enc_valid_o, enc_d_out}), 0);
    chk("rst_dec", 32'(dec_d_out), 0);
    rst = 1; ms = 0; ch_v = 0; ch_d = 0; prev_out = 0; dec_n = 0;
    exp_q.delete();
    repeat (TBD) exp_q.push_back(1'b0);
  endtask

  task automatic cycle(input logic en, input logic u);
    logic [2:0] ee;
    logic       e;
    enc_enable_i = en; enc_d_in = u;
    dec_enable = ch_v;
    dec_d_in = ch_d ^ (ch_v ? flip_for(dec_n) : 2'b00);
    ee = en ? {1'b1, u ^ ms[1] ^ ms[0], u ^ ms[0]} : 3'b000;
    if (en) begin
      ms = {u, ms[1]};
      exp_q.push_back(u);
    end
    @(posedge clk); #1;
    chk("enc_loop", 32'({enc_valid_o, enc_d_out}), 32'(ee));
    if (ch_v) begin
      e = exp_q.pop_front();
      chk($sformatf("dec_sym%0d", dec_n), 32'(dec_d_out), 32'(e));
      dec_n++;
      prev_out = e;
    end else
      chk("dec_hold", 32'(dec_d_out), 32'(prev_out));
    ch_v = enc_valid_o; ch_d = enc_d_out;
  endtask

  initial begin
    tv[0] = '{1'b1, 1'b1, 1'b1, 2'b11};
    tv[1] = '{1'b1, 1'b0, 1'b1, 2'b10};
    tv[2] = '{1'b1, 1'b1, 1'b1, 2'b00};
    tv[3] = '{1'b1, 1'b1, 1'b1, 2'b01};
    tv[4] = '{1'b0, 1'b1, 1'b0, 2'b00};
    tv[5] = '{1'b1, 1'b0, 1'b1, 2'b01};
    tv[6] = '{1'b1, 1'b1, 1'b1, 2'b00};
    tv[7] = '{1'b0, 1'b0, 1'b0, 2'b00};
    for (int i = 0; i < 1000; i++) bits[i] = 1'($urandom_range(0, 1));

    do_reset();
    for (int i = 0; i < 8; i++) begin
      enc_enable_i = tv[i].en; enc_d_in = tv[i].u;
      @(posedge clk); #1;
      chk($sformatf("enc_vec%0d", i), 32'({enc_valid_o, enc_d_out}), 32'({tv[i].v, tv[i].d}));
      chk("dec_idle", 32'(dec_d_out), 0);
    end

    do_reset();
    for (int i = 0; i < 80; i++) cycle(1'b1, 1'b0);

    do_reset();
    for (int i = 0; i < 1000; i++) cycle(1'b1, bits[i]);

    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, bits[i]);
      cycle(1'b0, 1'b0);
    end

    err_mode = 1;
    do_reset();
    for (int i = 0; i < 400; i++) cycle(1'b1, bits[i]);

    err_mode = 2;
    do_reset();
    for (int i = 0; i < 400; i++) cycle(1'b1, bits[i + 400]);

    err_mode = 0;
    do_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, bits[i]);
    do_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, bits[i + 100]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
